// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//   Shared TileLink C-channel definitions for the data-cache outer interface:
//   C-channel opcodes, the beat payload struct, arbiter state and requester
//   identifiers, and opcode classification helpers.
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam logic [2:0] TL_C_PROBE_ACK      = 3'h4;
    localparam logic [2:0] TL_C_PROBE_ACK_DATA = 3'h5;
    localparam logic [2:0] TL_C_RELEASE        = 3'h6;
    localparam logic [2:0] TL_C_RELEASE_DATA   = 3'h7;

    localparam int unsigned TL_DATA_W = 128;
    localparam int unsigned TL_ADDR_W = 32;
    localparam int unsigned TL_SRC_W  = 3;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           param;
        logic [3:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_ADDR_W-1:0] address;
        logic [TL_DATA_W-1:0] data;
    } tl_c_beat_t;

    typedef enum logic {S_IDLE, S_LOCK} c_arb_state_e;
    typedef enum logic {REQ_WB, REQ_PR} c_req_e;

    // Only the data-carrying C opcodes span a full line; anything else
    // (including illegal 0..3) is a single beat.
    function automatic logic is_multi_beat(input logic [2:0] op);
        return (op == TL_C_PROBE_ACK_DATA) || (op == TL_C_RELEASE_DATA);
    endfunction

    function automatic logic is_bad_opcode(input logic [2:0] op);
        return !((op == TL_C_PROBE_ACK) || (op == TL_C_PROBE_ACK_DATA) ||
                 (op == TL_C_RELEASE)   || (op == TL_C_RELEASE_DATA));
    endfunction

endpackage

// File: rtl/tl_pipe_reg.sv
// -----------------------------------------------------------------------------
// tl_pipe_reg
//   One-entry valid/ready register slice, generic over the payload type.
//   Accepts a new entry whenever empty or when the current entry drains in
//   the same cycle, so it sustains one transfer per cycle.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid_i/in_ready_o     upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i   downstream handshake, out_data_o payload
// -----------------------------------------------------------------------------
module tl_pipe_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic valid_q;
    T     data_q;

    // Depends only on register state and downstream ready, never on in_valid_i.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (in_ready_o) begin
                valid_q <= in_valid_i;
            end
            if (in_valid_i && in_ready_o) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/dcache_c_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_c_channel_arbiter
//   Shares the outer TileLink C channel between the writeback unit (wb_*,
//   1 or BEATS beats per message) and the probe unit (pr_*, ProbeAck, no data).
//   Round-robin between message boundaries; grant stays locked to the owner for
//   a whole multi-beat burst. A one-entry register stage drives out_*.
// Ports:
//   clock, reset                       clock, asynchronous active-high reset
//   wb_valid/wb_ready, wb_*            writeback requester beat + payload
//   pr_valid/pr_ready, pr_*            probe requester beat + payload
//   out_valid/out_ready, out_*         registered C beat towards L2
//   busy                               burst locked or output stage occupied
//   err_opcode                         pulse after accepting an opcode outside 4..7
// -----------------------------------------------------------------------------
module dcache_c_channel_arbiter
    import dcache_pkg::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SRC_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [2:0]        wb_opcode,
    input  logic [2:0]        wb_param,
    input  logic [3:0]        wb_size,
    input  logic [SRC_W-1:0]  wb_source,
    input  logic [ADDR_W-1:0] wb_address,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pr_valid,
    output logic              pr_ready,
    input  logic [2:0]        pr_opcode,
    input  logic [2:0]        pr_param,
    input  logic [3:0]        pr_size,
    input  logic [SRC_W-1:0]  pr_source,
    input  logic [ADDR_W-1:0] pr_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_opcode,
    output logic [2:0]        out_param,
    output logic [3:0]        out_size,
    output logic [SRC_W-1:0]  out_source,
    output logic [ADDR_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err_opcode
);

    localparam int unsigned CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [3:0]        size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } beat_t;

    c_arb_state_e      state_q, state_d;
    c_req_e            owner_q, owner_d;
    c_req_e            last_q, last_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic              load;
    logic              grant_wb, grant_pr;
    logic              wb_fire, pr_fire, fire;
    beat_t             sel_beat, out_beat;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        grant_wb   = 1'b0;
        grant_pr   = 1'b0;

        // Each grant looks only at the *other* requester's valid, so a
        // requester's ready never depends on its own valid.
        if (state_q == S_LOCK) begin
            grant_wb = (owner_q == REQ_WB);
            grant_pr = (owner_q == REQ_PR);
        end else begin
            grant_wb = !pr_valid || (last_q == REQ_PR);
            grant_pr = !wb_valid || (last_q == REQ_WB);
        end

        wb_ready = grant_wb && load;
        pr_ready = grant_pr && load;
        wb_fire  = wb_valid && wb_ready;
        pr_fire  = pr_valid && pr_ready;
        fire     = wb_fire || pr_fire;

        if (wb_fire) begin
            sel_beat = '{wb_opcode, wb_param, wb_size, wb_source, wb_address, wb_data};
        end else begin
            sel_beat = '{pr_opcode, pr_param, pr_size, pr_source, pr_address, '0};
        end

        err_d = fire && is_bad_opcode(sel_beat.opcode);

        if (fire) begin
            if (state_q == S_IDLE) begin
                last_d = wb_fire ? REQ_WB : REQ_PR;
                if (is_multi_beat(sel_beat.opcode)) begin
                    state_d    = S_LOCK;
                    owner_d    = wb_fire ? REQ_WB : REQ_PR;
                    beat_cnt_d = CNT_W'(1);
                end
            end else if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                state_d    = S_IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= REQ_WB;
            last_q     <= REQ_WB;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    tl_pipe_reg #(
        .T (beat_t)
    ) u_out_reg (
        .clk         (clock),
        .rst         (reset),
        .in_valid_i  (fire),
        .in_ready_o  (load),
        .in_data_i   (sel_beat),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_beat)
    );

    assign out_opcode  = out_beat.opcode;
    assign out_param   = out_beat.param;
    assign out_size    = out_beat.size;
    assign out_source  = out_beat.source;
    assign out_address = out_beat.address;
    assign out_data    = out_beat.data;
    assign busy        = (state_q == S_LOCK) || out_valid;
    assign err_opcode  = err_q;

endmodule

// File: tb/tb_dcache_c_channel_arbiter.sv
module tb_dcache_c_channel_arbiter;

    localparam int BEATS = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         wb_valid = 1'b0, pr_valid = 1'b0, out_ready = 1'b0;
    logic         wb_ready, pr_ready, out_valid, busy, err_opcode;
    logic [2:0]   wb_opcode = '0, wb_param = '0, pr_opcode = '0, pr_param = '0;
    logic [3:0]   wb_size = '0, pr_size = '0;
    logic [2:0]   wb_source = '0, pr_source = '0;
    logic [31:0]  wb_address = '0, pr_address = '0;
    logic [127:0] wb_data = '0;
    logic [2:0]   out_opcode, out_param, out_source;
    logic [3:0]   out_size;
    logic [31:0]  out_address;
    logic [127:0] out_data;

    dcache_c_channel_arbiter #(.BEATS(BEATS), .DATA_W(128), .ADDR_W(32), .SRC_W(3)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_opcode(wb_opcode), .wb_param(wb_param),
        .wb_size(wb_size), .wb_source(wb_source), .wb_address(wb_address), .wb_data(wb_data),
        .pr_valid(pr_valid), .pr_ready(pr_ready), .pr_opcode(pr_opcode), .pr_param(pr_param),
        .pr_size(pr_size), .pr_source(pr_source), .pr_address(pr_address),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_param(out_param), .out_size(out_size), .out_source(out_source),
        .out_address(out_address), .out_data(out_data),
        .busy(busy), .err_opcode(err_opcode)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]   op;
        logic [2:0]   param;
        logic [3:0]   size;
        logic [2:0]   src;
        logic [31:0]  addr;
        logic [127:0] data;
    } msg_t;

    int n_vec = 0, n_err = 0;

    // Pending messages per requester; data of beat k is base data + k.
    msg_t wb_q[$], pr_q[$];
    int   wb_beat = 0, pr_beat = 0;
    bit   wb_hold = 0, pr_hold = 0;
    int   wb_pct = 100, pr_pct = 100, ordy_pct = 100;
    int   order[$];     // observed acceptances: 0 = WB, 1 = PR
    int   err_seen = 0;

    // Reference model: owner (-1 none), beats left in burst, last grantee, output register.
    int           m_owner, m_left, m_last;
    bit           m_ov, m_err;
    msg_t         m_out;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int msg_len(input logic [2:0] op);
        return (op >= 4 && op % 2 == 1) ? BEATS : 1;
    endfunction

    function automatic msg_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [127:0] d);
        msg_t m;
        m.op = op; m.param = 3'($urandom_range(7)); m.size = 4'd6;
        m.src = 3'($urandom_range(7)); m.addr = addr; m.data = d;
        return m;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_last = 0; m_ov = 0; m_err = 0; m_out = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wb_valid = 1'b0; pr_valid = 1'b0; out_ready = 1'b0;
        wb_q.delete(); pr_q.delete(); order.delete();
        wb_beat = 0; pr_beat = 0; wb_hold = 0; pr_hold = 0; err_seen = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_opcode, 1'b0);
        check("rst_out_opcode", out_opcode, 3'd0);
        check("rst_out_data", out_data, 128'd0);
        reset = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs, check readys, advance model.
    task automatic tick(input int ordy_mode);
        msg_t w, p, acc;
        int   cand;
        bit   space, wb_acc, pr_acc;
        @(negedge clock);
        check("out_valid", out_valid, m_ov);
        check("busy", busy, (m_owner >= 0) || m_ov);
        check("err_opcode", err_opcode, m_err);
        if (err_opcode) err_seen++;
        if (m_ov) begin
            check("out_opcode", out_opcode, m_out.op);
            check("out_param", out_param, m_out.param);
            check("out_size", out_size, m_out.size);
            check("out_source", out_source, m_out.src);
            check("out_address", out_address, m_out.addr);
            check("out_data", out_data, m_out.data);
        end
        w = '0; p = '0;
        wb_valid = (wb_q.size() > 0) && (wb_hold || $urandom_range(99) < wb_pct);
        if (wb_q.size() > 0) begin
            w = wb_q[0]; w.data = w.data + 128'(wb_beat);
        end
        {wb_opcode, wb_param, wb_size, wb_source, wb_address, wb_data} = w;
        pr_valid = (pr_q.size() > 0) && (pr_hold || $urandom_range(99) < pr_pct);
        if (pr_q.size() > 0) begin
            p = pr_q[0]; p.data = '0;
        end
        {pr_opcode, pr_param, pr_size, pr_source, pr_address} = {p.op, p.param, p.size, p.src, p.addr};
        out_ready = (ordy_mode < 0) ? ($urandom_range(99) < ordy_pct) : ordy_mode[0];
        #1;
        space = !m_ov || out_ready;
        if (m_owner >= 0)              cand = m_owner;
        else if (wb_valid && pr_valid) cand = 1 - m_last;
        else if (wb_valid)             cand = 0;
        else if (pr_valid)             cand = 1;
        else                           cand = -1;
        wb_acc = space && wb_valid && cand == 0;
        pr_acc = space && pr_valid && cand == 1;
        if (wb_valid) check("wb_ready", wb_ready, wb_acc);
        if (pr_valid) check("pr_ready", pr_ready, pr_acc);
        if (wb_valid && wb_ready) order.push_back(0);
        if (pr_valid && pr_ready) order.push_back(1);
        acc = wb_acc ? w : p;
        m_err = 0;
        if (space) m_ov = wb_acc || pr_acc;
        if (wb_acc || pr_acc) begin
            m_out = acc;
            m_err = (acc.op < 4);
            if (m_owner < 0) begin
                m_last = cand;
                if (msg_len(acc.op) > 1) begin
                    m_owner = cand; m_left = msg_len(acc.op) - 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end
        if (wb_acc) begin
            wb_beat++; wb_hold = 0;
            if (wb_beat == msg_len(w.op)) begin void'(wb_q.pop_front()); wb_beat = 0; end
        end else wb_hold = wb_valid;
        if (pr_acc) begin
            pr_beat++; pr_hold = 0;
            if (pr_beat == msg_len(p.op)) begin void'(pr_q.pop_front()); pr_beat = 0; end
        end else pr_hold = pr_valid;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((wb_q.size() > 0 || pr_q.size() > 0 || m_ov || m_owner >= 0) && n < budget) begin
            tick(-1); n++;
        end
        check("drain_timeout", n < budget, 1'b1);
    endtask

    task automatic wait_wb_beats(input int beats, input int ordy_mode);
        int n = 0;
        while (wb_beat < beats && n < 50) begin tick(ordy_mode); n++; end
        check("wb_beat_timeout", n < 50, 1'b1);
    endtask

    initial begin
        // Test 3: both single-beat, both held valid from reset -> PR, WB, PR, WB.
        do_reset();
        wb_pct = 100; pr_pct = 100; ordy_pct = 100;
        repeat (2) wb_q.push_back(mk(3'd6, 32'h1000_0000, 128'h0));
        repeat (2) pr_q.push_back(mk(3'd4, 32'h2000_0000, 128'h0));
        drain(40);
        check("t3_count", order.size(), 4);
        if (order.size() >= 4) begin
            check("t3_g0", order[0], 1); check("t3_g1", order[1], 0);
            check("t3_g2", order[2], 1); check("t3_g3", order[3], 0);
        end

        // Test 1: lone ProbeAck.
        do_reset();
        pr_q.push_back(mk(3'd4, 32'h8000_0040, 128'h0));
        drain(20);
        check("t1_order", order.size(), 1);

        // Test 2: ReleaseData burst, probe arrives during beat 2 and waits.
        do_reset();
        wb_q.push_back(mk(3'd7, 32'h8000_0100, 128'h1));
        pr_q.push_back(mk(3'd4, 32'h8000_0200, 128'h0));
        pr_pct = 0;
        wait_wb_beats(1, 1);
        pr_pct = 100;
        drain(40);
        check("t2_count", order.size(), 5);
        if (order.size() >= 5) begin
            check("t2_o3", order[3], 0); check("t2_o4", order[4], 1);
        end

        // Test 4: L2 stalls for 3 cycles while ProbeAckData beat 2 sits in the output stage.
        do_reset();
        wb_q.push_back(mk(3'd5, 32'h8000_0300, 128'hA0));
        wait_wb_beats(2, 1);
        repeat (3) tick(0);
        drain(40);
        check("t4_count", order.size(), 4);

        // Test 5: asynchronous reset mid-burst, then probe wins first.
        do_reset();
        wb_q.push_back(mk(3'd7, 32'h8000_0400, 128'hB0));
        wait_wb_beats(2, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_async_out_valid", out_valid, 1'b0);
        check("t5_async_busy", busy, 1'b0);
        do_reset();
        wb_q.push_back(mk(3'd6, 32'h8000_0500, 128'h0));
        pr_q.push_back(mk(3'd4, 32'h8000_0600, 128'h0));
        drain(40);
        check("t5_count", order.size(), 2);
        if (order.size() >= 1) check("t5_first_pr", order[0], 1);

        // Test 6: illegal opcode 2 forwarded, one error pulse, no lock.
        do_reset();
        wb_q.push_back(mk(3'd2, 32'h8000_0700, 128'hC0));
        drain(20);
        tick(1);
        check("t6_err_pulses", err_seen, 1);

        // Randomized traffic, all opcodes, random gaps and back-pressure.
        do_reset();
        for (int e = 0; e < 15; e++) begin
            wb_pct = $urandom_range(100); pr_pct = $urandom_range(100);
            ordy_pct = $urandom_range(30, 100);
            for (int c = 0; c < 200; c++) begin
                if (wb_q.size() < 3)
                    wb_q.push_back(mk(3'($urandom_range(7)), $urandom, {$urandom, $urandom, $urandom, $urandom}));
                if (pr_q.size() < 3)
                    pr_q.push_back(mk(($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd4, $urandom, 128'h0));
                tick(-1);
            end
        end
        ordy_pct = 100; wb_pct = 100; pr_pct = 100;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
